odo_round_key_sched: RTL and testbench
======================================

# odo_round_key_sched

Parametrised Odo round-key scheduler: on a start request for one epoch period it streams that period's round keys, round 0 to NUM_ROUNDS-1, over a valid/ready interface. Keys come from a period×round table, constant or run-time loadable (see Configuration). It replaces the family of per-round fixed lookup blocks. It sits between the epoch/period tracker and the Odo hash round pipeline, which consumes one key per round.

## Interface
- KEY_W, 10, round-key width in bits
- NUM_ROUNDS, 10, keys streamed per period (rounds 0..NUM_ROUNDS-1)
- NUM_PERIODS, 9, valid period indices 0..NUM_PERIODS-1
- PERIOD_W, 4, period index width; must satisfy 2^PERIOD_W >= NUM_PERIODS
- RND_W, $clog2(NUM_ROUNDS), round index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a key stream; sampled only when busy=0
- period  in  PERIOD_W  period for the stream, sampled with start
- busy  out  1  stream in progress
- err  out  1  one-cycle pulse: start rejected, period >= NUM_PERIODS
- key_valid  out  1  key/key_round/key_last hold a valid beat
- key_ready  in  1  consumer accepts the beat
- key  out  KEY_W  round key
- key_round  out  RND_W  round index of key
- key_last  out  1  beat is round NUM_ROUNDS-1

## Operation
- FSM states: IDLE, STREAM.
- IDLE, start=1, period < NUM_PERIODS: latch period; load table[period][0] into key, key_round=0, key_valid=1, busy=1; go to STREAM.
- IDLE, start=1, period >= NUM_PERIODS: err=1 for one cycle; stay IDLE; all key outputs unchanged.
- STREAM, key_valid & key_ready: if key_round < NUM_ROUNDS-1, load the next round's key and increment key_round, with key_valid staying 1. Else clear key_valid and busy and go to IDLE.
- STREAM, key_ready=0: key, key_round and key_last are held stable; key_valid stays 1.
- start in STREAM is ignored. It is neither queued nor flagged.
- key_last = (key_round == NUM_ROUNDS-1) & key_valid.
- Reset values: busy=0, err=0, key_valid=0, key=0, key_round=0, key_last=0, FSM=IDLE.
- Reset asserted mid-stream aborts the stream immediately. No further beats are produced until a new start.

## Timing
- The start-to-first-beat latency is 1 cycle. If start is sampled at edge k, key_valid=1 with round 0 holds after edge k.
- Throughput is one key per cycle while key_ready=1. A full stream takes NUM_ROUNDS cycles.
- The last handshake at edge m drops busy and key_valid after edge m. A new start is first sampled at edge m+1.
- Table lookup is combinational from the latched period and the next round index. All outputs are registered.

## Configuration
- ODO_KEY_LOAD_EN defined:
  - Adds ports wr_en (in, 1), wr_period (in, PERIOD_W), wr_round (in, RND_W), wr_key (in, KEY_W), wr_err (out, 1).
  - The table is held in registers, and reset reloads the package defaults.
  - A write takes effect at the edge it is sampled, and only when busy=0 and start=0 in that cycle.
  - A write with busy=1 or start=1, or with an out-of-range index, is dropped and wr_err pulses for 1 cycle. wr_err resets to 0.
- ODO_KEY_LOAD_EN undefined: the table is constant logic built from the package defaults; the write ports do not exist.

## Structure
- Package odo_key_pkg holds:
  - The default KEY_W, NUM_ROUNDS and NUM_PERIODS.
  - The default key table as a constant array [NUM_PERIODS][NUM_ROUNDS].
  - The FSM state enum.
  - In the default table, the round-8 column for periods 0..8 is 337, 36e, 2ab, 312, 312, 010, 150, 0a7, 0c0 (hex).
- Sub-module odo_key_table holds the storage and combinational read port (period, round → key), plus the write port under ODO_KEY_LOAD_EN. The FSM and output registers stay in odo_round_key_sched.

## Test plan
- Reset, then start with period=2 and key_ready=1: 10 beats on consecutive cycles. The round-8 beat carries key=0x2ab; key_last is set only on round 9; busy drops after the last beat.
- Period=5, with key_ready low for 3 cycles at round 8: key holds 0x010 and key_round holds 8 while stalled. The stream then completes with no beat lost or duplicated.
- Start with period=9 (out of range): err high for exactly 1 cycle; busy and key_valid stay 0.
- Start pulsed again while streaming period 0: ignored. The round-8 key remains 0x337, and only 10 beats are produced.
- Reset asserted at round 4 of period 7: all outputs are 0 immediately. A new start with period 8 produces round 8 = 0x0c0.
- ODO_KEY_LOAD_EN: write period 3, round 8 = 0x1ff while idle, then start period 3: round-8 beat = 0x1ff. A write attempted while busy is dropped with a wr_err pulse. Reset restores 0x312.

Source files
------------

// File: rtl/odo_key_pkg.sv
// Shared defaults for the Odo round-key scheduler: sizes, default key table, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package odo_key_pkg;

    localparam int KEY_W_DEF       = 10;
    localparam int NUM_ROUNDS_DEF  = 10;
    localparam int NUM_PERIODS_DEF = 9;

    typedef logic [KEY_W_DEF-1:0] key_t;

    localparam key_t KEY_TABLE [NUM_PERIODS_DEF][NUM_ROUNDS_DEF] = '{
        '{10'h1a3, 10'h05c, 10'h2e7, 10'h391, 10'h0f4, 10'h26b, 10'h118, 10'h3cd, 10'h337, 10'h084},
        '{10'h2d0, 10'h14e, 10'h09b, 10'h3a6, 10'h271, 10'h0e2, 10'h35f, 10'h1b8, 10'h36e, 10'h047},
        '{10'h0c9, 10'h31a, 10'h284, 10'h17d, 10'h3e0, 10'h05b, 10'h2a2, 10'h196, 10'h2ab, 10'h3f1},
        '{10'h16f, 10'h2b4, 10'h0d8, 10'h343, 10'h1e5, 10'h3b0, 10'h07a, 10'h2c1, 10'h312, 10'h10d},
        '{10'h38c, 10'h061, 10'h1f3, 10'h2ee, 10'h0b7, 10'h154, 10'h3d9, 10'h226, 10'h312, 10'h09e},
        '{10'h0e8, 10'h27f, 10'h3a1, 10'h134, 10'h2c6, 10'h08d, 10'h1db, 10'h360, 10'h010, 10'h2f5},
        '{10'h25a, 10'h1c7, 10'h04e, 10'h3f9, 10'h113, 10'h2a8, 10'h0b5, 10'h17e, 10'h150, 10'h3c2},
        '{10'h31d, 10'h0a0, 10'h2f6, 10'h1e9, 10'h38b, 10'h044, 10'h1ac, 10'h2d3, 10'h0a7, 10'h161},
        '{10'h0f2, 10'h35d, 10'h168, 10'h2b7, 10'h04a, 10'h3e5, 10'h219, 10'h0cc, 10'h0c0, 10'h183}
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Out-of-table indices read as zero so wider parameterisations stay defined.
    function automatic key_t default_key(input int unsigned p, input int unsigned r);
        if (p < NUM_PERIODS_DEF && r < NUM_ROUNDS_DEF)
            return KEY_TABLE[p[3:0]][r[3:0]];
        return '0;
    endfunction

endpackage

// File: rtl/odo_key_table.sv
// Period x round key store, combinational read; registered and writable with ODO_KEY_LOAD_EN.
// Writes land at the sampling edge when allowed; rejected writes pulse wr_err one cycle later.
module odo_key_table
    import odo_key_pkg::*;
#(
    parameter int KEY_W       = KEY_W_DEF,
    parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
    parameter int NUM_PERIODS = NUM_PERIODS_DEF,
    parameter int PERIOD_W    = 4,
    parameter int RND_W       = $clog2(NUM_ROUNDS)
) (
`ifdef ODO_KEY_LOAD_EN
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_allow,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [RND_W-1:0]    wr_round,
    input  logic [KEY_W-1:0]    wr_key,
    output logic                wr_err,
`endif
    input  logic [PERIOD_W-1:0] rd_period,
    input  logic [RND_W-1:0]    rd_round,
    output logic [KEY_W-1:0]    rd_key
);

`ifdef ODO_KEY_LOAD_EN
    logic [KEY_W-1:0] tbl [NUM_PERIODS][NUM_ROUNDS];
    logic             wr_in_range;
    logic             wr_ok;
    logic             rd_in_range;

    assign wr_in_range = (32'(wr_period) < NUM_PERIODS) && (32'(wr_round) < NUM_ROUNDS);
    assign wr_ok       = wr_en && wr_allow && wr_in_range;
    assign rd_in_range = (32'(rd_period) < NUM_PERIODS) && (32'(rd_round) < NUM_ROUNDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PERIODS; p++)
                for (int r = 0; r < NUM_ROUNDS; r++)
                    tbl[p][r] <= KEY_W'(default_key(p, r));
            wr_err <= 1'b0;
        end else begin
            if (wr_ok)
                tbl[wr_period][wr_round] <= wr_key;
            wr_err <= wr_en && !wr_ok;
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_in_range)
            rd_key = tbl[rd_period][rd_round];
    end
`else
    assign rd_key = KEY_W'(default_key(32'(rd_period), 32'(rd_round)));
`endif

endmodule

// File: rtl/odo_round_key_sched.sv
// Streams NUM_ROUNDS round keys for a requested period; first beat 1 cycle after start, 1 key/cycle.
// key_ready low holds the current beat stable; optional table loading via ODO_KEY_LOAD_EN.
module odo_round_key_sched
    import odo_key_pkg::*;
#(
    parameter int KEY_W       = KEY_W_DEF,
    parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
    parameter int NUM_PERIODS = NUM_PERIODS_DEF,
    parameter int PERIOD_W    = 4,
    parameter int RND_W       = $clog2(NUM_ROUNDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    output logic                busy,
    output logic                err,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [KEY_W-1:0]    key,
    output logic [RND_W-1:0]    key_round,
    output logic                key_last
`ifdef ODO_KEY_LOAD_EN
    ,
    input  logic                wr_en,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [RND_W-1:0]    wr_round,
    input  logic [KEY_W-1:0]    wr_key,
    output logic                wr_err
`endif
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   per_q, per_d;
    logic [KEY_W-1:0]      key_d;
    logic [RND_W-1:0]      round_d;
    logic                  valid_d, last_d, busy_d, err_d;

    logic [PERIOD_W-1:0]   rd_period;
    logic [RND_W-1:0]      rd_round;
    logic [RND_W-1:0]      next_round;
    logic [KEY_W-1:0]      rd_key;
    logic                  period_ok;

    assign next_round = key_round + RND_W'(1);
    assign period_ok  = 32'(period) < NUM_PERIODS;

    // In IDLE the table is addressed by the incoming request, in STREAM by the latched period.
    assign rd_period = (state_q == IDLE) ? period : per_q;
    assign rd_round  = (state_q == IDLE) ? '0 : next_round;

    odo_key_table #(
        .KEY_W       (KEY_W),
        .NUM_ROUNDS  (NUM_ROUNDS),
        .NUM_PERIODS (NUM_PERIODS),
        .PERIOD_W    (PERIOD_W),
        .RND_W       (RND_W)
    ) u_table (
`ifdef ODO_KEY_LOAD_EN
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_allow  (!busy && !start),
        .wr_period (wr_period),
        .wr_round  (wr_round),
        .wr_key    (wr_key),
        .wr_err    (wr_err),
`endif
        .rd_period (rd_period),
        .rd_round  (rd_round),
        .rd_key    (rd_key)
    );

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        key_d   = key;
        round_d = key_round;
        valid_d = key_valid;
        last_d  = key_last;
        busy_d  = busy;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (period_ok) begin
                        per_d   = period;
                        key_d   = rd_key;
                        round_d = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        last_d  = (LAST_RND == '0);
                        state_d = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (key_valid && key_ready) begin
                    if (key_round == LAST_RND) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        key_d   = rd_key;
                        round_d = next_round;
                        last_d  = (next_round == LAST_RND);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            per_q     <= '0;
            key       <= '0;
            key_round <= '0;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            key       <= key_d;
            key_round <= round_d;
            key_valid <= valid_d;
            key_last  <= last_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_odo_round_key_sched.sv
// Scoreboard bench for odo_round_key_sched: directed streams, stalls, rejects, reset abort.
module tb_odo_round_key_sched;

    typedef struct packed {
        logic [9:0] key;
        logic [3:0] rnd;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] period;
    logic       busy;
    logic       err;
    logic       key_valid;
    logic       key_ready;
    logic [9:0] key;
    logic [3:0] key_round;
    logic       key_last;
`ifdef ODO_KEY_LOAD_EN
    logic       wr_en;
    logic [3:0] wr_period;
    logic [3:0] wr_round;
    logic [9:0] wr_key;
    logic       wr_err;
`endif

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    logic [9:0] ref_tab [9][10] = '{
        '{10'h1a3, 10'h05c, 10'h2e7, 10'h391, 10'h0f4, 10'h26b, 10'h118, 10'h3cd, 10'h337, 10'h084},
        '{10'h2d0, 10'h14e, 10'h09b, 10'h3a6, 10'h271, 10'h0e2, 10'h35f, 10'h1b8, 10'h36e, 10'h047},
        '{10'h0c9, 10'h31a, 10'h284, 10'h17d, 10'h3e0, 10'h05b, 10'h2a2, 10'h196, 10'h2ab, 10'h3f1},
        '{10'h16f, 10'h2b4, 10'h0d8, 10'h343, 10'h1e5, 10'h3b0, 10'h07a, 10'h2c1, 10'h312, 10'h10d},
        '{10'h38c, 10'h061, 10'h1f3, 10'h2ee, 10'h0b7, 10'h154, 10'h3d9, 10'h226, 10'h312, 10'h09e},
        '{10'h0e8, 10'h27f, 10'h3a1, 10'h134, 10'h2c6, 10'h08d, 10'h1db, 10'h360, 10'h010, 10'h2f5},
        '{10'h25a, 10'h1c7, 10'h04e, 10'h3f9, 10'h113, 10'h2a8, 10'h0b5, 10'h17e, 10'h150, 10'h3c2},
        '{10'h31d, 10'h0a0, 10'h2f6, 10'h1e9, 10'h38b, 10'h044, 10'h1ac, 10'h2d3, 10'h0a7, 10'h161},
        '{10'h0f2, 10'h35d, 10'h168, 10'h2b7, 10'h04a, 10'h3e5, 10'h219, 10'h0cc, 10'h0c0, 10'h183}
    };

    odo_round_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .period    (period),
        .busy      (busy),
        .err       (err),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .key_round (key_round),
        .key_last  (key_last)
`ifdef ODO_KEY_LOAD_EN
        ,
        .wr_en     (wr_en),
        .wr_period (wr_period),
        .wr_round  (wr_round),
        .wr_key    (wr_key),
        .wr_err    (wr_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got round %0d key 0x%0h, expected no beat", key_round, key);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_key",   32'(key),       32'(b.key));
                chk("beat_round", 32'(key_round), 32'(b.rnd));
                chk("beat_last",  32'(key_last),  32'(b.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input int p, input bit ovr, input logic [9:0] ovr_key);
        for (int r = 0; r < 10; r++) begin
            beat_t b;
            b.key  = (ovr && r == 8) ? ovr_key : ref_tab[p][r];
            b.rnd  = 4'(r);
            b.last = (r == 9);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_stream(input logic [3:0] p);
        period = p;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL stream_timeout: busy still 1 after %0d cycles, expected 0", cyc);
        end
    endtask

    task automatic chk_drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
        chk({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        chk({tag, "_key"},       32'(key),       32'd0);
        chk({tag, "_key_round"}, 32'(key_round), 32'd0);
        chk({tag, "_key_last"},  32'(key_last),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        period    = '0;
        key_ready = 1'b1;
`ifdef ODO_KEY_LOAD_EN
        wr_en     = 1'b0;
        wr_period = '0;
        wr_round  = '0;
        wr_key    = '0;
`endif
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full-rate stream, period 2.
        push_stream(2, 1'b0, '0);
        start_stream(4'd2);
        chk("p2_first_valid", 32'(key_valid), 32'd1);
        chk("p2_first_busy",  32'(busy),      32'd1);
        wait_idle(cyc);
        chk("p2_cycles", 32'(cyc), 32'd10);
        chk("p2_valid_after", 32'(key_valid), 32'd0);
        chk("p2_last_after",  32'(key_last),  32'd0);
        chk_drained("p2_drained");

        // Period 5 with a 3-cycle stall on round 8.
        push_stream(5, 1'b0, '0);
        start_stream(4'd5);
        for (int i = 0; i < 8; i++) tick();
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_key",   32'(key),       32'h010);
            chk("stall_round", 32'(key_round), 32'd8);
            chk("stall_valid", 32'(key_valid), 32'd1);
            tick();
        end
        key_ready = 1'b1;
        wait_idle(cyc);
        chk_drained("p5_drained");

        // Out-of-range period is rejected with a single err pulse.
        start_stream(4'd9);
        chk("err_pulse",      32'(err),       32'd1);
        chk("err_busy",       32'(busy),      32'd0);
        chk("err_valid",      32'(key_valid), 32'd0);
        tick();
        chk("err_one_cycle",  32'(err),       32'd0);
        chk("err_busy_later", 32'(busy),      32'd0);

        // start while streaming period 0 is ignored.
        push_stream(0, 1'b0, '0);
        start_stream(4'd0);
        for (int i = 0; i < 3; i++) tick();
        period = 4'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("restart_no_err", 32'(err), 32'd0);
        wait_idle(cyc);
        tick();
        chk("restart_not_queued", 32'(busy), 32'd0);
        chk_drained("p0_drained");

        // Reset during round 4 of period 7 aborts; then period 8 streams cleanly.
        push_stream(7, 1'b0, '0);
        start_stream(4'd7);
        for (int i = 0; i < 4; i++) tick();
        chk("p7_round4", 32'(key_round), 32'd4);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("abort_no_beats", 32'(key_valid), 32'd0);
        push_stream(8, 1'b0, '0);
        start_stream(4'd8);
        wait_idle(cyc);
        chk("p8_cycles", 32'(cyc), 32'd10);
        chk_drained("p8_drained");

`ifdef ODO_KEY_LOAD_EN
        // Idle write, then stream sees the new round-8 key.
        wr_en = 1'b1; wr_period = 4'd3; wr_round = 4'd8; wr_key = 10'h1ff;
        tick();
        wr_en = 1'b0;
        chk("wr_ok_no_err", 32'(wr_err), 32'd0);
        wr_en = 1'b1; wr_period = 4'd9; wr_round = 4'd0; wr_key = 10'h000;
        tick();
        wr_en = 1'b0;
        chk("wr_range_err", 32'(wr_err), 32'd1);
        tick();
        chk("wr_range_err_clr", 32'(wr_err), 32'd0);

        push_stream(3, 1'b1, 10'h1ff);
        start_stream(4'd3);
        tick();
        wr_en = 1'b1; wr_period = 4'd3; wr_round = 4'd0; wr_key = 10'h000;
        tick();
        wr_en = 1'b0;
        chk("wr_busy_err", 32'(wr_err), 32'd1);
        tick();
        chk("wr_busy_err_clr", 32'(wr_err), 32'd0);
        wait_idle(cyc);
        chk_drained("p3_loaded_drained");

        // Dropped write left round 0 intact.
        push_stream(3, 1'b1, 10'h1ff);
        start_stream(4'd3);
        wait_idle(cyc);
        chk_drained("p3_again_drained");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("wr_err_reset", 32'(wr_err), 32'd0);
        push_stream(3, 1'b0, '0);
        start_stream(4'd3);
        wait_idle(cyc);
        chk_drained("p3_default_drained");
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
